// File: rtl/data_sram_responder_if.sv
// Data SRAM bus: request/address handshake plus in-order response.
// master = initiator (drives req side), slave = responder.
interface data_sram_responder_if;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_req,
      output data_sram_wr,
      output data_sram_size,
      output data_sram_addr,
      output data_sram_wstrb,
      output data_sram_wdata,
      input  data_sram_addr_ok,
      input  data_sram_data_ok,
      input  data_sram_rdata
   );

   modport slave (
      input  data_sram_req,
      input  data_sram_wr,
      input  data_sram_size,
      input  data_sram_addr,
      input  data_sram_wstrb,
      input  data_sram_wdata,
      output data_sram_addr_ok,
      output data_sram_data_ok,
      output data_sram_rdata
   );
endinterface

// File: rtl/data_sram_responder.sv
// Data SRAM responder: in-order request queue with fixed minimum latency.
// Ports: clk, resetn (async active-low), bus (data_sram_responder_if.slave).
module data_sram_responder #(
   parameter int AW      = 10,
   parameter int LATENCY = 2,
   parameter int QDEPTH  = 4
) (
   input logic                  clk,
   input logic                  resetn,
   data_sram_responder_if.slave bus
);
   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam logic [3:0] CD_INIT = 4'(LATENCY - 1);
   localparam logic [PW:0] QFULL = (PW + 1)'(QDEPTH);

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] idx;
      logic [3:0]    wstrb;
      logic [31:0]   wdata;
   } entry_t;

   entry_t        q  [QDEPTH];
   logic [3:0]    cd [QDEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW:0]   count;
   logic [31:0]   mem [2**AW];

   entry_t hd;
   logic   accept;
   logic   pop;
   logic   unused_bits;

   assign unused_bits = ^{bus.data_sram_size,
                          bus.data_sram_addr[1:0],
                          bus.data_sram_addr[31:AW+2]};

   assign hd     = q[head];
   // addr_ok looks only at registered occupancy, never at req
   assign bus.data_sram_addr_ok = (count < QFULL);
   assign accept = bus.data_sram_req & bus.data_sram_addr_ok;
   assign pop    = (count != '0) && (cd[head] == 4'd0);

   assign bus.data_sram_data_ok = pop;
   assign bus.data_sram_rdata   =
      (pop && !hd.wr) ? mem[hd.idx] : 32'h0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < QDEPTH; i++)
            cd[i] <= '0;
      end else begin
         for (int i = 0; i < QDEPTH; i++)
            if (cd[i] != 4'd0)
               cd[i] <= cd[i] - 4'd1;
         if (accept) begin
            cd[tail] <= CD_INIT;
            tail     <= tail + 1'b1;
         end
         if (pop)
            head <= head + 1'b1;
         unique case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload is only meaningful while counted as outstanding
   always_ff @(posedge clk) begin
      if (accept) begin
         q[tail].wr    <= bus.data_sram_wr;
         q[tail].idx   <= bus.data_sram_addr[AW+1:2];
         q[tail].wstrb <= bus.data_sram_wstrb;
         q[tail].wdata <= bus.data_sram_wdata;
      end
   end

   // Stores commit at the pop edge so later loads see them
   always_ff @(posedge clk) begin
      if (pop && hd.wr) begin
         for (int b = 0; b < 4; b++)
            if (hd.wstrb[b])
               mem[hd.idx][8*b +: 8] <= hd.wdata[8*b +: 8];
      end
   end
endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder.
// Random traffic against a timestamp-based queue/memory model.
module tb_data_sram_responder;
   localparam int AW = 10;
   localparam int NW = 2**AW;
   localparam int QD = 4;
   localparam int L0 = 2;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   data_sram_responder_if bus0 ();
   data_sram_responder_if bus1 ();
   data_sram_responder_if bus2 ();

   data_sram_responder #(.AW(AW), .LATENCY(L0), .QDEPTH(QD)) dut (
      .clk(clk), .resetn(resetn), .bus(bus0));
   data_sram_responder #(.AW(AW), .LATENCY(1), .QDEPTH(QD)) dut1 (
      .clk(clk), .resetn(resetn), .bus(bus1));
   data_sram_responder #(.AW(AW), .LATENCY(6), .QDEPTH(QD)) dut2 (
      .clk(clk), .resetn(resetn), .bus(bus2));

   int checks = 0;
   int errors = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pre(int i);
      return (32'(i) * 32'h9E3779B9) ^ 32'hA5A50000;
   endfunction

   typedef struct {
      bit          wr;
      int          idx;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      int          t;
   } req_t;

   req_t        mq [$];
   logic [31:0] mmem [NW];
   int          edge_n = 0;

   task automatic drive(bit r, bit w, logic [31:0] a,
                        logic [3:0] s, logic [31:0] d);
      bus0.data_sram_req   = r;
      bus0.data_sram_wr    = w;
      bus0.data_sram_size  = 2'd2;
      bus0.data_sram_addr  = a;
      bus0.data_sram_wstrb = s;
      bus0.data_sram_wdata = d;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   // Called just after a falling edge with inputs already set.
   task automatic tick(string tag);
      bit          eok, edok, acc, r_wr;
      logic [31:0] erd, r_addr, r_wd;
      logic [3:0]  r_st;
      req_t        h;
      eok  = mq.size() < QD;
      edok = (mq.size() > 0) && (edge_n >= mq[0].t + L0 - 1);
      erd  = 32'h0;
      if (edok && !mq[0].wr)
         erd = mmem[mq[0].idx];
      chk({tag, ".addr_ok"}, 32'(bus0.data_sram_addr_ok), 32'(eok));
      chk({tag, ".data_ok"}, 32'(bus0.data_sram_data_ok), 32'(edok));
      chk({tag, ".rdata"}, bus0.data_sram_rdata, erd);
      acc    = bus0.data_sram_req && eok;
      r_wr   = bus0.data_sram_wr;
      r_addr = bus0.data_sram_addr;
      r_st   = bus0.data_sram_wstrb;
      r_wd   = bus0.data_sram_wdata;
      @(posedge clk);
      edge_n++;
      if (edok) begin
         h = mq.pop_front();
         if (h.wr)
            for (int b = 0; b < 4; b++)
               if (h.wstrb[b])
                  mmem[h.idx][8*b +: 8] = h.wdata[8*b +: 8];
      end
      if (acc)
         mq.push_back('{wr: r_wr, idx: int'((r_addr >> 2) % NW),
                        wstrb: r_st, wdata: r_wd, t: edge_n});
      @(negedge clk);
   endtask

   task automatic wait_resp(string tag, logic [31:0] exp);
      for (int k = 0; k < 20; k++) begin
         if (bus0.data_sram_data_ok) begin
            chk(tag, bus0.data_sram_rdata, exp);
            idle();
            tick(tag);
            return;
         end
         idle();
         tick(tag);
      end
      chk({tag, ".timeout"}, 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && mq.size() > 0; k++) begin
         idle();
         tick("drain");
      end
      chk("drain.empty", 32'(mq.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      logic [31:0] a;
      idle();
      bus1.data_sram_req = 1'b0;
      bus1.data_sram_wr = 1'b0;
      bus1.data_sram_size = 2'd2;
      bus1.data_sram_addr = '0;
      bus1.data_sram_wstrb = '0;
      bus1.data_sram_wdata = '0;
      bus2.data_sram_req = 1'b0;
      bus2.data_sram_wr = 1'b0;
      bus2.data_sram_size = 2'd2;
      bus2.data_sram_addr = '0;
      bus2.data_sram_wstrb = '0;
      bus2.data_sram_wdata = '0;
      for (int i = 0; i < NW; i++) begin
         dut.mem[i]  = pre(i);
         dut1.mem[i] = pre(i);
         dut2.mem[i] = pre(i);
         mmem[i]     = pre(i);
      end
      #3;
      chk("rst.addr_ok", 32'(bus0.data_sram_addr_ok), 32'd1);
      chk("rst.data_ok", 32'(bus0.data_sram_data_ok), 32'd0);
      chk("rst.rdata", bus0.data_sram_rdata, 32'h0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // store then load back
      drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
      tick("s033.st");
      idle();
      wait_resp("s033.st_rd", 32'h0);
      drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
      tick("s033.ld");
      wait_resp("s033.ld_rd", 32'hDEADBEEF);
      drain();

      // partial byte store merge
      dut.mem[4] = 32'h11223344;
      mmem[4]    = 32'h11223344;
      drive(1'b1, 1'b1, 32'h12, 4'h4, 32'h00AA0000);
      tick("s034.st");
      drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
      tick("s034.ld");
      wait_resp("s034.st_rd", 32'h0);
      wait_resp("s034.ld_rd", 32'h11AA3344);
      drain();

      // store immediately followed by load of the same word
      drive(1'b1, 1'b1, 32'h0, 4'hF, 32'h55);
      tick("s036.st");
      drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      tick("s036.ld");
      wait_resp("s036.st_rd", 32'h0);
      chk("s036.ld_ok", 32'(bus0.data_sram_data_ok), 32'd1);
      chk("s036.ld_rd", bus0.data_sram_rdata, 32'h55);
      idle();
      tick("s036.tail");
      drain();

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         a = {$urandom_range(0, 255) << 12, 32'(0)}
             | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, a,
               4'($urandom), $urandom);
         tick("rnd");
      end
      drain();

      // back-pressure with long latency
      for (int c = 0; c < 15; c++) begin
         bus2.data_sram_req  = (c <= 7);
         bus2.data_sram_wr   = 1'b0;
         bus2.data_sram_addr = 32'h20;
         chk($sformatf("q035.aok%0d", c), 32'(bus2.data_sram_addr_ok),
             32'((c < 4) || (c >= 7)));
         chk($sformatf("q035.dok%0d", c), 32'(bus2.data_sram_data_ok),
             32'((c >= 6 && c <= 9) || c == 13));
         if (c == 6)
            chk("q035.rd", bus2.data_sram_rdata, pre(8));
         @(negedge clk);
      end
      bus2.data_sram_req = 1'b0;
      repeat (4) @(negedge clk);

      // reset with three stores outstanding
      for (int k = 0; k < 3; k++) begin
         bus2.data_sram_req   = 1'b1;
         bus2.data_sram_wr    = 1'b1;
         bus2.data_sram_addr  = 32'((40 + k) * 4);
         bus2.data_sram_wstrb = 4'hF;
         bus2.data_sram_wdata = 32'hBAD00000 + 32'(k);
         @(negedge clk);
      end
      bus2.data_sram_req = 1'b0;
      chk("r037.pre_dok", 32'(bus2.data_sram_data_ok), 32'd0);
      #2 resetn = 1'b0;
      #1;
      chk("r037.aok", 32'(bus2.data_sram_addr_ok), 32'd1);
      chk("r037.dok", 32'(bus2.data_sram_data_ok), 32'd0);
      chk("r037.rd", bus2.data_sram_rdata, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      mq.delete();
      chk("r032.acc", 32'(bus0.data_sram_addr_ok), 32'd1);
      for (int k = 0; k < 10; k++) begin
         chk("r037.stale", 32'(bus2.data_sram_data_ok), 32'd0);
         if (k == 0)
            drive(1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
         else
            idle();
         tick("r032");
      end
      for (int k = 0; k < 3; k++)
         chk($sformatf("r037.mem%0d", 40 + k), dut2.mem[40 + k],
             pre(40 + k));

      // single-cycle latency streaming and address aliasing
      prev = 0;
      for (int c = 0; c < 11; c++) begin
         a = (c == 4) ? 32'h1000 : 32'h40 + 32'(4 * c);
         bus1.data_sram_req  = (c < 10);
         bus1.data_sram_wr   = 1'b0;
         bus1.data_sram_addr = a;
         if (c < 10)
            chk("l038.aok", 32'(bus1.data_sram_addr_ok), 32'd1);
         if (c > 0) begin
            chk($sformatf("l038.dok%0d", c),
                32'(bus1.data_sram_data_ok), 32'd1);
            chk($sformatf("l038.rd%0d", c), bus1.data_sram_rdata,
                pre(prev));
         end
         if (c == 5)
            chk("l038.alias", bus1.data_sram_rdata, 32'hA5A50000);
         prev = int'((a >> 2) % NW);
         @(negedge clk);
      end
      chk("l038.end", 32'(bus1.data_sram_data_ok), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter AW, default 10: word-address bits; the memory holds 2^AW 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2: minimum cycles from request acceptance to data_ok; legal range 1..15.
REQ-003 SHALL have parameter QDEPTH, default 4: number of outstanding requests; power of two, at least 2.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port data_sram_req  input  1  the initiator presents a request.
REQ-007 SHALL have port data_sram_wr  input  1  1 = store, 0 = load.
REQ-008 SHALL have port data_sram_size  input  2  0 = byte, 1 = halfword, 2 = word; informational only.
REQ-009 SHALL have port data_sram_addr  input  32  byte address.
REQ-010 SHALL have port data_sram_wstrb  input  4  byte enables for stores.
REQ-011 SHALL have port data_sram_wdata  input  32  store data, already lane-aligned.
REQ-012 SHALL have port data_sram_addr_ok  output  1  request accepted this cycle when high together with req.
REQ-013 SHALL have port data_sram_data_ok  output  1  one-cycle response pulse for the oldest outstanding request.
REQ-014 SHALL have port data_sram_rdata  output  32  full load word, valid while data_ok is high.

Function
REQ-015 SHALL accept a request in exactly the cycles where data_sram_req and data_sram_addr_ok are both high (handshake).
REQ-016 SHALL drive addr_ok = (outstanding count < QDEPTH); no combinational path from req or from the current-cycle response.
REQ-017 SHALL on acceptance push {wr, addr[AW+1:2], wstrb, wdata, countdown = LATENCY-1} into an in-order queue.
REQ-018 SHALL decrement every valid entry's countdown once per cycle, saturating at 0.
REQ-019 SHALL assert data_ok combinationally in any cycle where the queue is non-empty and the head countdown is 0, then pop the head at that edge.
REQ-020 SHALL, for a request accepted at edge T, issue data_ok no earlier than the cycle following edge T+LATENCY-1 (LATENCY=1 gives data_ok in the next cycle).
REQ-021 SHALL issue responses strictly in acceptance order, at most one per cycle; back-to-back accepts with LATENCY met yield data_ok on consecutive cycles.
REQ-022 SHALL apply no back-pressure on data_ok; the initiator always consumes the response.
REQ-023 SHALL perform the store memory write at the head-pop edge, writing only the bytes enabled by wstrb; data_ok for a store has rdata = 0.
REQ-024 SHALL return, for a load, the memory word at head address as of the response cycle, so it reflects every earlier-accepted store.
REQ-025 SHALL ignore addr[1:0] and addr[31:AW+2]; the index wraps modulo 2^AW, and rdata is never lane-shifted.
REQ-026 SHALL allow accept and pop at the same edge; the count is unchanged, and the freed slot becomes visible through addr_ok only in the next cycle.
REQ-027 SHALL keep the outstanding count in the range 0..QDEPTH, with the queue pointers wrapping modulo QDEPTH.
REQ-028 SHALL drive data_ok = 0 and rdata = 0 when the queue is empty.

Reset
REQ-029 SHALL, while resetn = 0, clear the pointers, count and all countdowns immediately (asynchronous): addr_ok = 1, data_ok = 0, rdata = 0.
REQ-030 SHALL discard requests outstanding at reset; no data_ok is issued for them after release, and their stores are not performed.
REQ-031 SHALL not reset memory contents; the bench preloads memory through hierarchical access.
REQ-032 SHALL accept a request in the first cycle after resetn rises.

Verification
REQ-033 SHALL pass this scenario (defaults): store addr 0x10, wstrb 0xF, wdata 0xDEADBEEF, accepted at edge 0 -> data_ok in cycle 2; then a load of 0x10 -> rdata 0xDEADBEEF.
REQ-034 SHALL pass this scenario: memory word 4 = 0x11223344; store addr 0x12, wstrb 0x4, wdata 0x00AA0000; then a load of 0x10 -> rdata 0x11AA3344.
REQ-035 SHALL pass this scenario: req held high with no pops possible (4 loads inside the latency window) -> addr_ok falls after 4 accepts; the 5th request is accepted only in the cycle after the first data_ok.
REQ-036 SHALL pass this scenario: store 0x55 to addr 0x0 immediately followed by a load of 0x0 -> the load returns 0x55 with data_ok one cycle after the store's data_ok.
REQ-037 SHALL pass this scenario: 3 requests outstanding, then resetn pulsed low mid-cycle -> addr_ok = 1 and data_ok = 0 asynchronously, no stale data_ok after release, and the target memory words are unchanged.
REQ-038 SHALL pass this scenario: LATENCY=1, continuous loads -> one accept and one data_ok every cycle with steady-state count 1, and addr 0x1000 aliases to word 0 when AW=10.
